color_sort_ctrl: RTL and testbench
==================================

// Module: color_sort_ctrl
// PURPOSE
//  Upstream decision stage for the servo PWM driver. Drives the colour sensor filter
//  selects (s2/s3) and counts sensor_out edges over a fixed gate for red, green and blue.
//  Classifies the object and produces the 1-bit servo `state` (1 = divert, red objects).
//  Holds `state` for a fixed dwell so the servo completes its travel.
// PARAMETERS
//  GATE_CYCLES   250000    clocks per colour count window (10 ms @ 25 MHz)
//  SETTLE_CYCLES 25000     clocks after a filter change before counting (1 ms)
//  HOLD_CYCLES   75000000  clocks `state` is held after a red decision (3 s)
//  MIN_COUNT     50        max(r,g,b) below this means no object present
//  CNT_W         16        edge counter width; counters saturate at 2^CNT_W-1
// PORTS
//  clk         in   1      system clock (25 MHz)
//  rst_n       in   1      asynchronous active-low reset
//  sensor_out  in   1      sensor frequency output; asynchronous to clk
//  s2, s3      out  1,1    filter select: 00 red, 11 green, 01 blue
//  state       out  1      servo command: 1 divert (red), 0 pass
//  color       out  2      last class: 0 none, 1 red, 2 green, 3 blue
//  color_valid out  1      one-cycle pulse when `color` is updated
//  busy_hold   out  1      high while in HOLD
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=SEL_R; s2,s3=00; state=0; color=0; color_valid=0;
//   busy_hold=0; all counters=0; synchroniser flops=0.
//  sensor_out passes through a 2-FF synchroniser plus an edge register.
//   One rise is counted per 0->1 transition of the synchronised signal.
//  FSM, with one pass per colour c in {R,G,B}:
//   SEL_c: drive the s2/s3 code for c, clear the timer and edge count, go to SETTLE_c.
//   SETTLE_c: wait SETTLE_CYCLES clocks; edges are ignored. Then go to COUNT_c.
//   COUNT_c: count rises for exactly GATE_CYCLES clocks.
//    Latch the count into r/g/b; the count saturates and does not wrap.
//    Then go to SEL of the next colour; after B, go to CLASSIFY.
//   CLASSIFY (1 cycle): let m = max(r,g,b).
//    If m < MIN_COUNT, color=0.
//    Else if r>=g and r>=b, color=1.
//    Else if g>=b, color=2.
//    Else color=3. (Ties resolve R over G over B.)
//    color_valid=1 for this cycle only.
//    If color==1: state<=1 and go to HOLD. Otherwise state<=0 and go to SEL_R.
//   HOLD: busy_hold=1 and no sensing; s2/s3 stay at the blue code.
//    After HOLD_CYCLES clocks: state<=0, busy_hold<=0, go to SEL_R.
//  `state` changes only in CLASSIFY and at the end of HOLD.
//   It is registered and glitch-free.
//  A rise on the same clock as the gate closes is counted in the closing window.
//  A rise in the SEL cycle is not counted.
//  Deasserting reset mid-window or mid-HOLD returns to SEL_R; the partial count is discarded.
//  The scan loop is free-running: no start input, repeats indefinitely.
//  Latency from the SEL_R entry to color_valid:
//   3*(1+SETTLE_CYCLES+GATE_CYCLES)+1 clocks.
// TESTING (GATE_CYCLES=100, SETTLE_CYCLES=10, HOLD_CYCLES=50, MIN_COUNT=5, CNT_W=8)
//  1 Reset: rst_n=0 mid-run -> state=0, color=0, s2s3=00, color_valid=0
//    immediately, without waiting for a clk edge.
//  2 Red: sensor period 4 clk during R, 10 during G and B (~25/10/10)
//    -> color_valid at cycle 334 with color=1; state=1 for 50 clk, then 0.
//  3 No object: sensor period 40 for all colours (~2-3 counts)
//    -> color=0, state stays 0, next SEL_R with no HOLD.
//  4 Tie/blue: R=G=20 -> color=1 (R wins); R=10, G=10, B=25 -> color=3, state=0.
//  5 Saturation: CNT_W=4 with 25 rises in the window -> latched count=15, no wrap;
//    classification is still correct.
//  6 Reset in HOLD: rst_n pulse 20 clk into HOLD -> state=0 and busy_hold=0 at once;
//    the full scan restarts and the second color_valid lands 334 clk after release.

Source files
------------

// File: rtl/color_sort_if.sv
// Sensor/servo-side signal bundle of the colour sort controller.
// The controller owns the master view; the sensor/servo side uses slave.
interface color_sort_if;
  logic       sensor_out;
  logic       s2;
  logic       s3;
  logic       state;
  logic [1:0] color;
  logic       color_valid;
  logic       busy_hold;

  modport master (
    input  sensor_out,
    output s2, s3, state, color, color_valid, busy_hold
  );

  modport slave (
    output sensor_out,
    input  s2, s3, state, color, color_valid, busy_hold
  );
endinterface

// File: rtl/color_sort_ctrl.sv
// Colour sort decision stage: scans R/G/B filter counts, classifies the object
// and holds the servo divert command for a fixed dwell after a red decision.
module color_sort_ctrl #(
  parameter int unsigned GATE_CYCLES   = 250000,
  parameter int unsigned SETTLE_CYCLES = 25000,
  parameter int unsigned HOLD_CYCLES   = 75000000,
  parameter int unsigned MIN_COUNT     = 50,
  parameter int unsigned CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  color_sort_if.master bus
);

  localparam int unsigned MAX_GS  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (HOLD_CYCLES > MAX_GS) ? HOLD_CYCLES : MAX_GS;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] CLR_NONE  = 2'd0;
  localparam logic [1:0] CLR_RED   = 2'd1;
  localparam logic [1:0] CLR_GREEN = 2'd2;
  localparam logic [1:0] CLR_BLUE  = 2'd3;

  typedef enum logic [3:0] {
    SEL_R, SETTLE_R, COUNT_R,
    SEL_G, SETTLE_G, COUNT_G,
    SEL_B, SETTLE_B, COUNT_B,
    CLASSIFY, HOLD
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, r_q, r_d, g_q, g_d, b_q, b_d;
  logic             s2_q, s2_d, s3_q, s3_d;
  logic             state_q, state_d, valid_q, valid_d, busy_q, busy_d;
  logic [1:0]       color_q, color_d;
  logic [2:0]       sync_q;

  logic             rise;
  logic             settle_done, gate_done, hold_done;
  logic [CNT_W-1:0] cnt_inc, m_rg, m_rgb;
  logic [1:0]       class_c;

  // sync_q[1] is the synchronised sensor, sync_q[2] its previous value
  assign rise        = sync_q[1] & ~sync_q[2];
  assign settle_done = (timer_q == TMR_W'(SETTLE_CYCLES - 1));
  assign gate_done   = (timer_q == TMR_W'(GATE_CYCLES - 1));
  assign hold_done   = (timer_q == TMR_W'(HOLD_CYCLES - 1));
  assign cnt_inc     = (rise && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign m_rg        = (r_q >= g_q) ? r_q : g_q;
  assign m_rgb       = (m_rg >= b_q) ? m_rg : b_q;

  // Classification with ties resolved red over green over blue
  always_comb begin
    if (32'(m_rgb) < MIN_COUNT)            class_c = CLR_NONE;
    else if ((r_q >= g_q) && (r_q >= b_q)) class_c = CLR_RED;
    else if (g_q >= b_q)                   class_c = CLR_GREEN;
    else                                   class_c = CLR_BLUE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= SEL_R;
      timer_q <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= 1'b0;
      color_q <= CLR_NONE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      state_q <= state_d;
      color_q <= color_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      sync_q  <= {sync_q[1:0], bus.sensor_out};
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    timer_d = timer_q + TMR_W'(1);
    cnt_d   = cnt_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    state_d = state_q;
    color_d = color_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (fsm_q)
      SEL_R: begin
        timer_d = '0; cnt_d = '0; s2_d = 1'b0; s3_d = 1'b0; fsm_d = SETTLE_R;
      end
      SETTLE_R: if (settle_done) begin timer_d = '0; fsm_d = COUNT_R; end
      COUNT_R: begin
        cnt_d = cnt_inc;
        if (gate_done) begin timer_d = '0; r_d = cnt_inc; fsm_d = SEL_G; end
      end
      SEL_G: begin
        timer_d = '0; cnt_d = '0; s2_d = 1'b1; s3_d = 1'b1; fsm_d = SETTLE_G;
      end
      SETTLE_G: if (settle_done) begin timer_d = '0; fsm_d = COUNT_G; end
      COUNT_G: begin
        cnt_d = cnt_inc;
        if (gate_done) begin timer_d = '0; g_d = cnt_inc; fsm_d = SEL_B; end
      end
      SEL_B: begin
        timer_d = '0; cnt_d = '0; s2_d = 1'b0; s3_d = 1'b1; fsm_d = SETTLE_B;
      end
      SETTLE_B: if (settle_done) begin timer_d = '0; fsm_d = COUNT_B; end
      COUNT_B: begin
        cnt_d = cnt_inc;
        if (gate_done) begin timer_d = '0; b_d = cnt_inc; fsm_d = CLASSIFY; end
      end
      CLASSIFY: begin
        timer_d = '0;
        color_d = class_c;
        valid_d = 1'b1;
        if (class_c == CLR_RED) begin
          state_d = 1'b1; busy_d = 1'b1; fsm_d = HOLD;
        end else begin
          state_d = 1'b0; fsm_d = SEL_R;
        end
      end
      HOLD: if (hold_done) begin
        timer_d = '0; state_d = 1'b0; busy_d = 1'b0; fsm_d = SEL_R;
      end
      default: fsm_d = SEL_R;
    endcase
  end

  assign bus.s2          = s2_q;
  assign bus.s3          = s3_q;
  assign bus.state       = state_q;
  assign bus.color       = color_q;
  assign bus.color_valid = valid_q;
  assign bus.busy_hold   = busy_q;

endmodule

// File: tb/tb_color_sort_ctrl.sv
// Bench for color_sort_ctrl: a filter-aware sensor model drives two DUTs
// (8-bit and 4-bit counters) and results are compared with a rule-level model.
module tb_color_sort_ctrl;

  localparam int GATE   = 100;
  localparam int SETTLE = 10;
  localparam int HOLD   = 50;
  localparam int MINC   = 5;
  localparam int LAT    = 3 * (1 + SETTLE + GATE) + 1;
  localparam int BUDGET = 1000;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic sensor = 1'b0;
  int   per_r  = 10;
  int   per_g  = 10;
  int   per_b  = 10;
  int   ph     = 0;
  int   total  = 0;
  int   bad    = 0;

  color_sort_if bus8();
  color_sort_if bus4();
  assign bus8.sensor_out = sensor;
  assign bus4.sensor_out = sensor;

  color_sort_ctrl #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD),
                    .MIN_COUNT(MINC), .CNT_W(8))
    dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  color_sort_ctrl #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD),
                    .MIN_COUNT(MINC), .CNT_W(4))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  // Sensor responds to the selected filter with a square wave of the configured period
  always @(negedge clk) begin
    int p;
    case ({bus8.s2, bus8.s3})
      2'b00:   p = per_r;
      2'b11:   p = per_g;
      default: p = per_b;
    endcase
    if (p == 0) begin
      sensor = 1'b0;
      ph = 0;
    end else begin
      ph = (ph + 1 >= p) ? 0 : ph + 1;
      sensor = (ph < p / 2);
    end
  end

  function automatic int exp_cnt(input int per, input int w);
    int n;
    n = (per == 0) ? 0 : GATE / per;
    if (n > (1 << w) - 1) n = (1 << w) - 1;
    return n;
  endfunction

  function automatic logic [1:0] exp_color(input int pr, input int pg, input int pb, input int w);
    int r, g, b, m;
    r = exp_cnt(pr, w); g = exp_cnt(pg, w); b = exp_cnt(pb, w);
    m = r; if (g > m) m = g; if (b > m) m = b;
    if (m < MINC) return 2'd0;
    if (r >= g && r >= b) return 2'd1;
    if (g >= b) return 2'd2;
    return 2'd3;
  endfunction

  task automatic start_scan(input int pr, input int pg, input int pb);
    @(negedge clk);
    rst_n = 1'b0;
    per_r = pr; per_g = pg; per_b = pb;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk); #1;
      if (bus8.color_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus8.state, bus8.color, bus8.s2, bus8.s3, bus8.color_valid, bus8.busy_hold} !== 7'd0) begin
      bad++; $display("FAIL reset_init got=%b want=0000000",
        {bus8.state, bus8.color, bus8.s2, bus8.s3, bus8.color_valid, bus8.busy_hold}); end
    rst_n = 1'b1;
  endtask

  task automatic test_red;
    int lat, nh;
    logic v2;
    start_scan(4, 10, 10);
    wait_valid(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL red_latency got=%0d want=%0d", lat, LAT); end
    total++; if (bus8.color !== exp_color(4, 10, 10, 8)) begin bad++;
      $display("FAIL red_color got=%0d want=%0d", bus8.color, exp_color(4, 10, 10, 8)); end
    total++; if (bus4.color !== exp_color(4, 10, 10, 4)) begin bad++;
      $display("FAIL red_color4 got=%0d want=%0d", bus4.color, exp_color(4, 10, 10, 4)); end
    total++; if ({bus8.state, bus8.busy_hold} !== 2'b11) begin bad++;
      $display("FAIL red_state_busy got=%b want=11", {bus8.state, bus8.busy_hold}); end
    nh = 1; v2 = 1'b1;
    for (int i = 0; i < 4 * HOLD; i++) begin
      @(posedge clk); #1;
      if (i == 0) v2 = bus8.color_valid;
      if (!bus8.state) break;
      nh++;
    end
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL red_valid_pulse got=%b want=0", v2); end
    total++; if (nh !== HOLD) begin bad++; $display("FAIL red_hold_len got=%0d want=%0d", nh, HOLD); end
    total++; if (bus8.busy_hold !== 1'b0) begin bad++; $display("FAIL red_busy_end got=%b want=0", bus8.busy_hold); end
    wait_valid(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL red_rescan_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_reset_mid;
    int lat;
    start_scan(10, 10, 4);
    wait_valid(lat);
    repeat (150) begin @(posedge clk); #1; end
    total++; if ({bus8.s2, bus8.s3, bus8.color} !== 4'b1111) begin bad++;
      $display("FAIL mid_pre_reset got=%b want=1111", {bus8.s2, bus8.s3, bus8.color}); end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    total++; if ({bus8.state, bus8.color, bus8.s2, bus8.s3, bus8.color_valid, bus8.busy_hold} !== 7'd0) begin
      bad++; $display("FAIL reset_mid got=%b want=0000000",
        {bus8.state, bus8.color, bus8.s2, bus8.s3, bus8.color_valid, bus8.busy_hold}); end
  endtask

  task automatic test_no_object;
    int lat;
    start_scan(40, 40, 40);
    wait_valid(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL none_latency got=%0d want=%0d", lat, LAT); end
    total++; if ({bus8.color, bus8.state, bus8.busy_hold} !== 4'b0000) begin bad++;
      $display("FAIL none_result got=%b want=0000", {bus8.color, bus8.state, bus8.busy_hold}); end
    wait_valid(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL none_no_hold got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_tie_blue;
    int lat;
    start_scan(5, 5, 0);
    wait_valid(lat);
    total++; if ({bus8.color, bus4.color, bus8.state} !== {exp_color(5, 5, 0, 8), exp_color(5, 5, 0, 4), 1'b1}) begin
      bad++; $display("FAIL tie_red got=%b want=%b", {bus8.color, bus4.color, bus8.state},
        {exp_color(5, 5, 0, 8), exp_color(5, 5, 0, 4), 1'b1}); end
    start_scan(10, 10, 4);
    wait_valid(lat);
    total++; if ({bus8.color, bus4.color, bus8.state, bus8.busy_hold} !==
                 {exp_color(10, 10, 4, 8), exp_color(10, 10, 4, 4), 2'b00}) begin
      bad++; $display("FAIL blue got=%b want=%b", {bus8.color, bus4.color, bus8.state, bus8.busy_hold},
        {exp_color(10, 10, 4, 8), exp_color(10, 10, 4, 4), 2'b00}); end
  endtask

  task automatic test_saturation;
    int lat;
    start_scan(4, 8, 20);
    wait_valid(lat);
    total++; if (bus4.color !== exp_color(4, 8, 20, 4)) begin bad++;
      $display("FAIL sat_nowrap got=%0d want=%0d", bus4.color, exp_color(4, 8, 20, 4)); end
    start_scan(5, 4, 20);
    wait_valid(lat);
    total++; if (bus8.color !== exp_color(5, 4, 20, 8)) begin bad++;
      $display("FAIL sat_wide got=%0d want=%0d", bus8.color, exp_color(5, 4, 20, 8)); end
    total++; if (bus4.color !== exp_color(5, 4, 20, 4)) begin bad++;
      $display("FAIL sat_tie got=%0d want=%0d", bus4.color, exp_color(5, 4, 20, 4)); end
  endtask

  task automatic test_random;
    int pers [8];
    int lat, pr, pg, pb;
    logic [1:0] e8, e4;
    pers = '{0, 4, 5, 10, 20, 25, 50, 100};
    for (int k = 0; k < 6; k++) begin
      pr = pers[$urandom_range(0, 7)];
      pg = pers[$urandom_range(0, 7)];
      pb = pers[$urandom_range(0, 7)];
      e8 = exp_color(pr, pg, pb, 8);
      e4 = exp_color(pr, pg, pb, 4);
      start_scan(pr, pg, pb);
      wait_valid(lat);
      total++; if ({bus8.color, bus4.color, bus8.state} !== {e8, e4, (e8 == 2'd1)} || lat !== LAT) begin
        bad++; $display("FAIL rand_%0d per=%0d/%0d/%0d got=%b lat=%0d want=%b lat=%0d", k, pr, pg, pb,
          {bus8.color, bus4.color, bus8.state}, lat, {e8, e4, (e8 == 2'd1)}, LAT); end
    end
  endtask

  task automatic test_reset_in_hold;
    int lat;
    start_scan(4, 10, 10);
    wait_valid(lat);
    repeat (20) begin @(posedge clk); #1; end
    total++; if ({bus8.state, bus8.busy_hold} !== 2'b11) begin bad++;
      $display("FAIL hold_pre got=%b want=11", {bus8.state, bus8.busy_hold}); end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    total++; if ({bus8.state, bus8.busy_hold} !== 2'b00) begin bad++;
      $display("FAIL hold_reset got=%b want=00", {bus8.state, bus8.busy_hold}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL hold_restart_latency got=%0d want=%0d", lat, LAT); end
    total++; if (bus8.color !== 2'd1) begin bad++; $display("FAIL hold_restart_color got=%0d want=1", bus8.color); end
  endtask

  initial begin
    test_reset;
    test_red;
    test_reset_mid;
    test_no_object;
    test_tie_blue;
    test_saturation;
    test_random;
    test_reset_in_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
